// File: rtl/cnn_pkg.sv
// Shared types and window slot indices for the 2x2 pooling path.
// The window generator produces windows; the max_pool unit consumes them.
package cnn_pkg;

  localparam int PIX_W = 32;

  typedef logic signed [PIX_W-1:0] pixel_t;
  typedef pixel_t pool_win_t [0:3];

  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;

  // Reference reduction done by the downstream combinational max_pool unit.
  function automatic pixel_t pool_max(input pool_win_t w);
    pixel_t m;
    m = w[WIN_TL];
    for (int i = 1; i < 4; i++) begin
      if (w[i] > m) m = w[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One image row of pixels: a single write port and two combinational read
// ports returning the pixels at columns col-1 and col.
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int IMG_W      = 8,
  parameter int COL_W      = 3
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [COL_W-1:0]             waddr_i,
  input  logic signed [DATA_WIDTH-1:0] wdata_i,
  input  logic [COL_W-1:0]             rcol_i,
  output logic signed [DATA_WIDTH-1:0] rd_prev_o,
  output logic signed [DATA_WIDTH-1:0] rd_cur_o
);

  logic signed [DATA_WIDTH-1:0] r_mem [IMG_W];
  logic [COL_W-1:0]             w_prev_col;

  // Row storage carries no reset: contents are always rewritten before use.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  assign w_prev_col = rcol_i - COL_W'(1);
  assign rd_prev_o  = r_mem[w_prev_col];
  assign rd_cur_o   = r_mem[rcol_i];

endmodule

// File: rtl/cnn_pool_window_gen.sv
// Turns a raster pixel stream into non-overlapping 2x2 windows (stride 2)
// with a registered, valid/ready output feeding the max_pool unit.
module cnn_pool_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [DATA_WIDTH-1:0] out_window_o [0:3],
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         frame_done_o
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             r_row;
  logic signed [DATA_WIDTH-1:0] r_bl;
  logic signed [DATA_WIDTH-1:0] r_win [0:3];
  logic                         r_out_valid;
  logic                         r_last;
  logic                         r_frame_done;

  logic                         w_beat;
  logic                         w_lb_we;
  logic                         w_bl_we;
  logic                         w_complete;
  logic                         w_end_of_frame;
  logic signed [DATA_WIDTH-1:0] w_tl;
  logic signed [DATA_WIDTH-1:0] w_tr;

  assign in_ready_o     = !r_out_valid | out_ready_i;
  assign w_beat         = in_valid_i & in_ready_o;
  assign w_lb_we        = w_beat & ~r_row[0];
  assign w_bl_we        = w_beat &  r_row[0] & ~r_col[0];
  assign w_complete     = w_beat &  r_row[0] &  r_col[0];
  assign w_end_of_frame = (r_col == COL_MAX) && (r_row == ROW_MAX);

  cnn_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W),
    .COL_W      (COL_W)
  ) u_line_buf (
    .clk_i     (clk_i),
    .we_i      (w_lb_we),
    .waddr_i   (r_col),
    .wdata_i   (in_data_i),
    .rcol_i    (r_col),
    .rd_prev_o (w_tl),
    .rd_cur_o  (w_tr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_beat) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Bottom-left pixel waits here until its right-hand neighbour completes the block.
  always_ff @(posedge clk_i) begin
    if (w_bl_we) r_bl <= in_data_i;
  end

  // A completing beat can only be accepted when the output slot is free or
  // draining this cycle, so loading takes priority over clearing valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
    end else begin
      r_frame_done <= r_out_valid & out_ready_i & r_last;
      if (w_complete) begin
        r_out_valid    <= 1'b1;
        r_last         <= w_end_of_frame;
        r_win[WIN_TL]  <= w_tl;
        r_win[WIN_TR]  <= w_tr;
        r_win[WIN_BL]  <= r_bl;
        r_win[WIN_BR]  <= in_data_i;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_window_o = r_win;
  assign out_valid_o  = r_out_valid;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_cnn_pool_window_gen.sv
// Directed bench for cnn_pool_window_gen on a 4x4 image.
module tb_cnn_pool_window_gen;

  localparam int DW = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic signed [DW-1:0] in_data_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic signed [DW-1:0] out_window_o [0:3];
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 frame_done_o;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;
  logic last_vld;
  logic rand_rdy = 1'b0;
  logic [4*DW-1:0] got_q [$];
  int ofs [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  logic va [16];

  cnn_pool_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_W      (4),
    .IMG_H      (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .out_window_o (out_window_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .frame_done_o (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (out_valid_o && out_ready_i)
        got_q.push_back({out_window_o[0], out_window_o[1], out_window_o[2], out_window_o[3]});
      if (frame_done_o) fd_cnt++;
    end
  end

  always @(posedge clk_i) begin
    if (rand_rdy) begin
      #2 out_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_px(input int v, input int gap);
    int to;
    to = 0;
    in_data_i  = DW'(v);
    in_valid_i = 1'b1;
    #1;
    while (!in_ready_o && to < 300) begin
      @(negedge clk_i);
      to++;
    end
    if (to >= 300) check("in_ready_timeout", 0, 1);
    @(negedge clk_i);
    last_vld = out_valid_o;
    if (gap > 0) begin
      in_valid_i = 1'b0;
      repeat (gap) @(negedge clk_i);
    end
  endtask

  function automatic longint win_el(input logic [4*DW-1:0] w, input int e);
    logic signed [DW-1:0] p;
    p = w[4*DW-1-DW*e -: DW];
    return longint'(p);
  endfunction

  function automatic longint win_max(input logic [4*DW-1:0] w);
    longint m;
    m = win_el(w, 0);
    for (int e = 1; e < 4; e++) if (win_el(w, e) > m) m = win_el(w, e);
    return m;
  endfunction

  task automatic wait_windows(input int n);
    int to;
    to = 0;
    while (got_q.size() < n && to < 400) begin
      @(negedge clk_i);
      to++;
    end
    if (to >= 400) check("out_timeout", got_q.size(), n);
  endtask

  task automatic expect_windows(input string tag, input int base, input int nwin, input int nfd);
    wait_windows(nwin);
    repeat (4) @(negedge clk_i);
    check({tag, "_count"}, got_q.size(), nwin);
    for (int w = 0; w < nwin && w < got_q.size(); w++)
      for (int e = 0; e < 4; e++)
        check($sformatf("%s_w%0d_e%0d", tag, w, e), win_el(got_q[w], e),
              base + 16 * (w / 4) + ofs[(w % 4) * 4 + e]);
    check({tag, "_frame_done"}, fd_cnt, nfd);
    got_q.delete();
    fd_cnt = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid_o, 0);
    check({tag, "_frame_done"}, frame_done_o, 0);
    check({tag, "_in_ready"}, in_ready_o, 1);
    for (int e = 0; e < 4; e++) check($sformatf("%s_win%0d", tag, e), out_window_o[e], 0);
  endtask

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_reset_state("rst");
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1: plain frame, latency of each window
    for (int i = 0; i < 16; i++) begin
      send_px(i, 0);
      va[i] = last_vld;
    end
    in_valid_i = 1'b0;
    check("t1_vld_after4", va[4], 0);
    check("t1_vld_after5", va[5], 1);
    check("t1_vld_after6", va[6], 0);
    check("t1_vld_after7", va[7], 1);
    check("t1_vld_after12", va[12], 0);
    check("t1_vld_after13", va[13], 1);
    check("t1_vld_after15", va[15], 1);
    expect_windows("t1", 0, 4, 1);

    // 2: stall after the first window
    for (int i = 0; i < 6; i++) send_px(i, 0);
    out_ready_i = 1'b0;
    in_data_i   = DW'(6);
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t2_stall%0d_in_ready", c), in_ready_o, 0);
      check($sformatf("t2_stall%0d_valid", c), out_valid_o, 1);
      check($sformatf("t2_stall%0d_tl", c), out_window_o[0], 0);
      check($sformatf("t2_stall%0d_br", c), out_window_o[3], 5);
      @(negedge clk_i);
    end
    check("t2_tr_held", out_window_o[1], 1);
    check("t2_bl_held", out_window_o[2], 4);
    out_ready_i = 1'b1;
    for (int i = 6; i < 16; i++) send_px(i, 0);
    in_valid_i = 1'b0;
    expect_windows("t2", 0, 4, 1);

    // 3: signed pixels and downstream max
    for (int i = -8; i < 8; i++) send_px(i, 0);
    in_valid_i = 1'b0;
    wait_windows(4);
    if (got_q.size() >= 4) begin
      check("t3_max0", win_max(got_q[0]), -3);
      check("t3_max1", win_max(got_q[1]), -1);
      check("t3_max2", win_max(got_q[2]), 5);
      check("t3_max3", win_max(got_q[3]), 7);
    end
    expect_windows("t3", -8, 4, 1);

    // 4: reset mid-frame
    for (int i = 0; i < 7; i++) send_px(i, 0);
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_reset_state("t4_rst");
    rst_i = 1'b0;
    got_q.delete();
    fd_cnt = 0;
    @(negedge clk_i);
    for (int i = 100; i < 116; i++) send_px(i, 0);
    in_valid_i = 1'b0;
    expect_windows("t4", 100, 4, 1);

    // 5: two back-to-back frames under random backpressure
    rand_rdy = 1'b1;
    for (int i = 20; i < 52; i++) send_px(i, 0);
    in_valid_i = 1'b0;
    wait_windows(8);
    @(negedge clk_i);
    rand_rdy = 1'b0;
    @(negedge clk_i);
    out_ready_i = 1'b1;
    expect_windows("t5", 20, 8, 2);

    // 6: idle cycles between pixels
    for (int i = 0; i < 16; i++) begin
      send_px(i, 1 + (i % 2));
      if (((i / 4) % 2) == 0) check($sformatf("t6_even_row_vld_px%0d", i), last_vld, 0);
    end
    expect_windows("t6", 0, 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

endmodule
